// File: rtl/iot_event_gen.sv
// Serialises net per-device status changes into one change/on_off event per clock,
// using a round-robin arbiter over devices whose level differs from the last report.
module iot_event_gen #(
    parameter int unsigned N_DEV = 8,
    parameter int unsigned ID_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_DEV-1:0]  dev_status,
    input  logic              hold,
    output logic              change,
    output logic              on_off,
    output logic [ID_W-1:0]   dev_id,
    output logic              busy
);

    logic [N_DEV-1:0] status_q, status_d;
    logic [N_DEV-1:0] reported_q, reported_d;
    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic             change_q, change_d;
    logic             on_off_q, on_off_d;
    logic [ID_W-1:0]  dev_id_q, dev_id_d;
    logic             busy_q, busy_d;

    logic [N_DEV-1:0] pending;
    logic [N_DEV-1:0] grant_mask;
    logic [ID_W-1:0]  grant_idx;
    logic             grant_vld;

    assign pending = status_q ^ reported_q;

    // First pending device at or above ptr, wrapping past the top index.
    always_comb begin
        int unsigned idx;
        logic [ID_W-1:0] idx_w;
        grant_vld  = 1'b0;
        grant_idx  = '0;
        grant_mask = '0;
        idx        = 0;
        idx_w      = '0;
        for (int unsigned i = 0; i < N_DEV; i++) begin
            idx = 32'(ptr_q) + i;
            if (idx >= N_DEV) begin
                idx = idx - N_DEV;
            end
            idx_w = ID_W'(idx);
            if (!grant_vld && pending[idx_w]) begin
                grant_vld  = 1'b1;
                grant_idx  = idx_w;
            end
        end
        if (grant_vld && !hold) begin
            grant_mask[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        int unsigned nxt;
        status_d   = dev_status;
        reported_d = reported_q;
        ptr_d      = ptr_q;
        change_d   = 1'b0;
        on_off_d   = on_off_q;
        dev_id_d   = dev_id_q;
        nxt        = 0;
        if (grant_vld && !hold) begin
            nxt = 32'(grant_idx) + 1;
            if (nxt >= N_DEV) begin
                nxt = 0;
            end
            change_d              = 1'b1;
            on_off_d              = status_q[grant_idx];
            dev_id_d              = grant_idx;
            reported_d[grant_idx] = status_q[grant_idx];
            ptr_d                 = ID_W'(nxt);
        end
        busy_d = |(pending & ~grant_mask);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            status_q   <= '0;
            reported_q <= '0;
            ptr_q      <= '0;
            change_q   <= 1'b0;
            on_off_q   <= 1'b0;
            dev_id_q   <= '0;
            busy_q     <= 1'b0;
        end else begin
            status_q   <= status_d;
            reported_q <= reported_d;
            ptr_q      <= ptr_d;
            change_q   <= change_d;
            on_off_q   <= on_off_d;
            dev_id_q   <= dev_id_d;
            busy_q     <= busy_d;
        end
    end

    assign change = change_q;
    assign on_off = on_off_q;
    assign dev_id = dev_id_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_iot_event_gen.sv
// Directed bench for iot_event_gen: latency, drain order, hold, glitch cancel,
// reset mid-drain, wrap-around, and a monitor counter under random traffic.
module tb_iot_event_gen;

    localparam int unsigned N_DEV = 8;
    localparam int unsigned ID_W  = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic [N_DEV-1:0] dev_status;
    logic             hold;
    logic             change;
    logic             on_off;
    logic [ID_W-1:0]  dev_id;
    logic             busy;

    int unsigned total  = 0;
    int unsigned passed = 0;
    logic [7:0]  mon_cnt;

    iot_event_gen #(.N_DEV(N_DEV), .ID_W(ID_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .dev_status (dev_status),
        .hold       (hold),
        .change     (change),
        .on_off     (on_off),
        .dev_id     (dev_id),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Downstream monitor: +1 per on event, -1 per off event.
    always @(posedge clk) begin
        if (rst) begin
            mon_cnt <= 8'd0;
        end else if (change) begin
            mon_cnt <= on_off ? mon_cnt + 8'd1 : mon_cnt - 8'd1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_evt(input string tag, input logic c, input logic oo, input int id, input logic b);
        chk({tag, ".change"}, 32'(change), 32'(c));
        if (c) begin
            chk({tag, ".on_off"}, 32'(on_off), 32'(oo));
            chk({tag, ".dev_id"}, 32'(dev_id), 32'(id));
        end
        chk({tag, ".busy"}, 32'(busy), 32'(b));
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        hold       = 1'b0;
        dev_status = '0;
        step();
        rst = 1'b0;
        step();
    endtask

    function automatic logic [7:0] popcnt(input logic [N_DEV-1:0] v);
        logic [7:0] c = 8'd0;
        for (int i = 0; i < N_DEV; i++) c = c + 8'(v[i]);
        return c;
    endfunction

    initial begin
        rst        = 1'b1;
        hold       = 1'b0;
        dev_status = '0;

        // Reset state
        step();
        chk_evt("reset", 1'b0, 1'b0, 0, 1'b0);
        chk("reset.on_off", 32'(on_off), 32'd0);
        chk("reset.dev_id", 32'(dev_id), 32'd0);
        rst = 1'b0;
        step();

        // Single device on: event appears after E+1 only
        dev_status = 8'h20;
        step();
        chk_evt("single.E", 1'b0, 1'b0, 0, 1'b0);
        step();
        chk_evt("single.E1", 1'b1, 1'b1, 5, 1'b0);
        step();
        chk_evt("single.E2", 1'b0, 1'b0, 0, 1'b0);

        // All on, then all off, in index order from 0
        do_reset();
        dev_status = 8'hFF;
        step();
        chk_evt("allon.E", 1'b0, 1'b0, 0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            step();
            chk_evt($sformatf("allon.%0d", k), 1'b1, 1'b1, k, k < 7);
        end
        step();
        chk_evt("allon.done", 1'b0, 1'b0, 0, 1'b0);
        dev_status = 8'h00;
        step();
        chk_evt("alloff.E", 1'b0, 1'b0, 0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            step();
            chk_evt($sformatf("alloff.%0d", k), 1'b1, 1'b0, k, k < 7);
        end
        step();
        chk_evt("alloff.done", 1'b0, 1'b0, 0, 1'b0);

        // Glitch on device 3 under hold cancels itself
        do_reset();
        hold = 1'b1;
        dev_status = 8'h08;
        step();
        chk_evt("glitch.up", 1'b0, 1'b0, 0, 1'b0);
        dev_status = 8'h00;
        step();
        chk_evt("glitch.down", 1'b0, 1'b0, 0, 1'b1);
        step();
        chk_evt("glitch.gone", 1'b0, 1'b0, 0, 1'b0);
        hold = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk_evt($sformatf("glitch.rel%0d", k), 1'b0, 1'b0, 0, 1'b0);
        end

        // Hold for 10 cycles with devices 1 and 6 pending
        do_reset();
        hold = 1'b1;
        dev_status = 8'h42;
        for (int k = 0; k < 10; k++) begin
            step();
            chk($sformatf("hold.%0d.change", k), 32'(change), 32'd0);
        end
        chk("hold.busy", 32'(busy), 32'd1);
        hold = 1'b0;
        step();
        chk_evt("hold.ev1", 1'b1, 1'b1, 1, 1'b1);
        step();
        chk_evt("hold.ev6", 1'b1, 1'b1, 6, 1'b0);
        step();
        chk_evt("hold.done", 1'b0, 1'b0, 0, 1'b0);

        // Reset in the middle of an all-on drain
        do_reset();
        dev_status = 8'hFF;
        step();
        for (int k = 0; k < 3; k++) begin
            step();
            chk_evt($sformatf("mid.pre%0d", k), 1'b1, 1'b1, k, 1'b1);
        end
        rst = 1'b1;
        step();
        chk_evt("mid.rst", 1'b0, 1'b0, 0, 1'b0);
        chk("mid.rst.on_off", 32'(on_off), 32'd0);
        chk("mid.rst.dev_id", 32'(dev_id), 32'd0);
        rst = 1'b0;
        step();
        chk_evt("mid.E", 1'b0, 1'b0, 0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            step();
            chk_evt($sformatf("mid.post%0d", k), 1'b1, 1'b1, k, k < 7);
        end

        // Wrap-around: ptr at 7, only device 0 pending
        do_reset();
        dev_status = 8'h40;
        step();
        step();
        chk_evt("wrap.ev6", 1'b1, 1'b1, 6, 1'b0);
        dev_status = 8'h41;
        step();
        chk_evt("wrap.E", 1'b0, 1'b0, 0, 1'b0);
        step();
        chk_evt("wrap.ev0", 1'b1, 1'b1, 0, 1'b0);

        // Random traffic: monitor counter matches live device count after each drain
        do_reset();
        for (int burst = 0; burst < 40; burst++) begin
            bit drained;
            for (int k = 0; k < 100; k++) begin
                dev_status = N_DEV'($urandom);
                hold       = ($urandom_range(0, 3) == 0);
                step();
            end
            hold = 1'b0;
            step();
            step();
            drained = 1'b0;
            for (int k = 0; k < 3 * N_DEV && !drained; k++) begin
                if (!change && !busy) drained = 1'b1;
                else step();
            end
            chk($sformatf("rand.%0d.drain", burst), 32'(drained), 32'd1);
            chk($sformatf("rand.%0d.count", burst), 32'(mon_cnt), 32'(popcnt(dev_status)));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
